// File: rtl/uart_tx_ctrl_if.sv
// Host and shifter-side signals of the UART transmit sequencer.
// The slave modport is the sequencer's view; master is the host/shifter side.
interface uart_tx_ctrl_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] piso_data;
  logic       load_data;
  logic       shift;
  logic       data_bit;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start, tx_data, data_bit,
    input  piso_data, load_data, shift, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data, data_bit,
    output piso_data, load_data, shift, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames start/data/stop bits and paces an external PISO shifter.
// Define UART_PARITY_EN to insert a parity bit (even, or odd via PARITY_ODD) after data bit 7.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_ctrl_if.slave bus,
  output logic          tx
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

`ifdef UART_PARITY_EN
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`endif

  state_t        state_r, state_s;
  logic [BW-1:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic          stop_cnt_r, stop_cnt_s;
  logic [7:0]    piso_r, piso_s;
  logic          load_r, load_s;
  logic          shift_r, shift_s;
  logic          tx_r, tx_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          period_end_s;
  logic          pre_end_s;
`ifdef UART_PARITY_EN
  logic          parity_r, parity_s;
`endif

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_s      = state_r;
    baud_cnt_s   = baud_cnt_r;
    bit_idx_s    = bit_idx_r;
    stop_cnt_s   = stop_cnt_r;
    piso_s       = piso_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    tx_s         = tx_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
`ifdef UART_PARITY_EN
    parity_s     = parity_r;
`endif
    period_end_s = (baud_cnt_r == BAUD_LAST);
    pre_end_s    = (baud_cnt_r == BAUD_PRE);

    case (state_r)
      IDLE: begin
        baud_cnt_s = BAUD_ZERO;
        bit_idx_s  = 3'd0;
        stop_cnt_s = 1'b0;
        tx_s       = 1'b1;
        if (bus.tx_start) begin
          piso_s   = bus.tx_data;
          load_s   = 1'b1;
          busy_s   = 1'b1;
          tx_s     = 1'b0;
          state_s  = START;
`ifdef UART_PARITY_EN
          parity_s = frame_parity(bus.tx_data, (PARITY_ODD != 0));
`endif
        end else begin
          busy_s = 1'b0;
        end
      end

      START: begin
        // Shift during the final start-bit cycle so data bit 0 appears as DATA begins.
        shift_s = pre_end_s;
        if (period_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          bit_idx_s  = 3'd0;
          tx_s       = 1'b1;
          state_s    = DATA;
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_ONE;
        end
      end

      DATA: begin
        shift_s = pre_end_s && (bit_idx_r != 3'd7);
        if (period_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
`ifdef UART_PARITY_EN
            tx_s      = parity_r;
            state_s   = PARITY;
`else
            tx_s      = 1'b1;
            state_s   = STOP;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_ONE;
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (period_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          tx_s       = 1'b1;
          state_s    = STOP;
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_ONE;
        end
      end
`endif

      STOP: begin
        tx_s = 1'b1;
        if (period_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          if (stop_cnt_r == STOP_LAST) begin
            stop_cnt_s = 1'b0;
            done_s     = 1'b1;
            busy_s     = 1'b0;
            state_s    = IDLE;
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_ONE;
        end
      end

      default: begin
        state_s    = IDLE;
        baud_cnt_s = BAUD_ZERO;
        tx_s       = 1'b1;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_idx_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      piso_r     <= 8'h00;
      load_r     <= 1'b0;
      shift_r    <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef UART_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_idx_r  <= bit_idx_s;
      stop_cnt_r <= stop_cnt_s;
      piso_r     <= piso_s;
      load_r     <= load_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
`ifdef UART_PARITY_EN
      parity_r   <= parity_s;
`endif
    end
  end

  // Data bits come straight from the shifter's registered output.
  assign tx            = (state_r == DATA) ? bus.data_bit : tx_r;
  assign bus.piso_data = piso_r;
  assign bus.load_data = load_r;
  assign bus.shift     = shift_r;
  assign bus.tx_busy   = busy_r;
  assign bus.tx_done   = done_r;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit sequencer for the UART TX path. It accepts a byte with a start strobe and drives the external 8-bit parallel-in serial-out shifter through `load_data` and `shift`. It times each bit with a baud counter and frames the serial line with start, optional parity and stop bits. It sits between the host/register interface and the shifter, and owns the `tx` line.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit period; legal range ≥ 4.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when UART_PARITY_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- tx_start  in  1  request to send `tx_data`; sampled only in IDLE.
- tx_data  in  8  byte to send; sampled in the accept cycle.
- piso_data  out  8  held copy of the byte; feeds the shifter's parallel input.
- load_data  out  1  one-cycle load pulse to the shifter.
- shift  out  1  one-cycle shift pulse to the shifter.
- data_bit  in  1  serial bit returned from the shifter; valid one edge after `shift`.
- tx  out  1  UART serial line; idles high.
- tx_busy  out  1  high from accept until frame end.
- tx_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Clock/reset: clock is `clk`; reset is `reset`, asynchronous, active-low.
- Reset values: state=IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0, `load_data`=0, `shift`=0, `piso_data`=0, baud_cnt=0, bit_idx=0.
- Reset mid-frame aborts the frame immediately; `tx` returns high with no partial stop bit.
- Output timing: all outputs are registered. Exception: in DATA, `tx` = `data_bit`, a mux of registered signals only.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- baud_cnt counts 0..CLKS_PER_BIT-1 within each bit period. The last cycle of a period is baud_cnt==CLKS_PER_BIT-1; the state transition happens on that edge.
- IDLE:
  - `tx`=1.
  - On edge E0 with `tx_start`=1: `piso_data`<=`tx_data`, `load_data`<=1 for exactly one cycle (shifter loads at E0+1), `tx_busy`<=1, `tx`<=0, baud_cnt<=0, go START.
  - Parity bit is latched as `^tx_data` (XOR with PARITY_ODD when odd parity is selected).
- START: `tx`=0 for CLKS_PER_BIT cycles, then go DATA with bit_idx=0.
- DATA:
  - `tx`=`data_bit` for CLKS_PER_BIT cycles per bit, 8 bits, LSB first.
  - bit_idx increments at each period end.
  - After bit_idx==7, go PARITY if enabled, else STOP.
- Shift scheduling:
  - `shift` is high during the last cycle of START and of data bits 0..6: exactly 8 pulses per frame.
  - Register it at baud_cnt==CLKS_PER_BIT-2 so it is high while baud_cnt==CLKS_PER_BIT-1.
  - The shifter updates `data_bit` on the same edge that enters the next data period.
- PARITY: `tx`=latched parity for CLKS_PER_BIT cycles, then STOP.
- STOP:
  - `tx`=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final edge: `tx_done`<=1 for one cycle, `tx_busy`<=0, go IDLE.
- Frame length: frame length F = (10 + P + STOP_BITS - 1)*CLKS_PER_BIT cycles from E0 to the `tx_done` edge, where P=1 if parity is enabled, else 0.
- Busy/back-to-back rules:
  - `tx_start` while `tx_busy`=1 is ignored; there is no queuing.
  - `tx_start` held high through `tx_done` starts the next frame on the first IDLE cycle after `tx_done` (one idle-high cycle minimum between frames).
- Input stability: changes to `tx_data` after E0 do not affect the frame in flight.
- Counters: baud_cnt width is clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.

Optional Feature:
UART_PARITY_EN
- Defined: PARITY state is present, and one parity bit (even, or odd per PARITY_ODD) is sent after data bit 7.
- Undefined: PARITY state, the parity register and PARITY_ODD logic are absent; DATA goes directly to STOP, and the frame is 1 bit shorter.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, STOP_BITS=1, no parity; send 0xA5 → `tx` per 4-cycle period = 0,1,0,1,0,0,1,0,1,1; `load_data` one pulse at E0+1; 8 `shift` pulses; `tx_done` at E0+40; `tx_busy` high for exactly 40 cycles.
- Parity: UART_PARITY_EN, even parity; send 0x07 → parity bit 1 between data bit 7 and stop, `tx_done` at E0+44. With PARITY_ODD=1 and 0xA5 → parity bit 1.
- Two stop bits: STOP_BITS=2; send 0x00 → `tx` low for 36 cycles, high for 8, `tx_done` at E0+44.
- Busy ignore and back-to-back: pulse `tx_start` with 0x3C mid-frame of 0xA5 → ignored. Hold `tx_start` high with 0x3C through `tx_done` → new start bit one cycle after `tx_done`, correct 0x3C frame follows.
- Reset mid-frame: assert `reset` during data bit 3 → `tx`=1, `tx_busy`=0, `shift`=`load_data`=0 immediately. Release and send 0xFF → clean full frame.
- `tx_data` stability: change `tx_data` to 0x00 one cycle after E0 of a 0xA5 frame → line still carries 0xA5.
